// File: rtl/systolic_mac_pe.sv
// rtl/systolic_mac_pe.sv - systolic-array MAC processing element with double-buffered weight
module systolic_mac_pe #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int MUL_LEN = 2,
    parameter int ADD_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              weight_load,
    input  logic              weight_swap,
    output logic [DATA_W-1:0] weight_out,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_value,
    input  logic [ACC_W-1:0]  in_accumulate,
    input  logic              acc_clear,
    output logic              out_pass_valid,
    output logic [DATA_W-1:0] out_pass,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_accumulate,
    output logic              busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int LAT    = MUL_LEN + ADD_LEN;
    localparam int CNT_W  = $clog2(LAT + 1);

    logic [DATA_W-1:0]        weight_shadow;
    logic [DATA_W-1:0]        weight_active;

    logic                     accept;
    logic signed [PROD_W-1:0] value_ext;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] product_now;
    logic [ACC_W-1:0]         addend_now;
    logic [ACC_W-1:0]         prod_ext;

    // Multiply pipe carries the product plus the addend captured at accept
    logic                     mul_valid  [MUL_LEN];
    logic signed [PROD_W-1:0] mul_prod   [MUL_LEN];
    logic [ACC_W-1:0]         mul_addend [MUL_LEN];

    // Add pipe; its last stage is the south-facing output register
    logic                     add_valid  [ADD_LEN];
    logic [ACC_W-1:0]         add_sum    [ADD_LEN];

    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         count_next;

    assign accept      = in_valid & ~stall;
    assign value_ext   = {{DATA_W{in_value[DATA_W-1]}}, in_value};
    assign weight_ext  = {{DATA_W{weight_active[DATA_W-1]}}, weight_active};
    assign product_now = value_ext * weight_ext;
    assign addend_now  = acc_clear ? '0 : in_accumulate;

    // Sign-extend the full-width product onto the accumulate path
    assign prod_ext    = ACC_W'(mul_prod[MUL_LEN-1]);

    assign weight_out     = weight_shadow;
    assign out_valid      = add_valid[ADD_LEN-1];
    assign out_accumulate = add_sum[ADD_LEN-1];

    // Shadow/active weight pair; a swap always sees the shadow value from before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            weight_shadow <= '0;
            weight_active <= '0;
        end else if (!stall) begin
            if (weight_load) begin
                weight_shadow <= weight_in;
            end
            if (weight_swap) begin
                weight_active <= weight_shadow;
            end
        end
    end

    // West-to-east activation pass-through; data only moves with a valid beat
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pass_valid <= 1'b0;
            out_pass       <= '0;
        end else if (!stall) begin
            out_pass_valid <= in_valid;
            if (in_valid) begin
                out_pass <= in_value;
            end
        end
    end

    // Multiply pipeline: stage 0 multiplies with the pre-swap active weight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_LEN; i++) begin
                mul_valid[i]  <= 1'b0;
                mul_prod[i]   <= '0;
                mul_addend[i] <= '0;
            end
        end else if (!stall) begin
            mul_valid[0] <= in_valid;
            if (in_valid) begin
                mul_prod[0]   <= product_now;
                mul_addend[0] <= addend_now;
            end
            for (int i = 1; i < MUL_LEN; i++) begin
                mul_valid[i] <= mul_valid[i-1];
                if (mul_valid[i-1]) begin
                    mul_prod[i]   <= mul_prod[i-1];
                    mul_addend[i] <= mul_addend[i-1];
                end
            end
        end
    end

    // Add pipeline: wrapping sum, data held when no valid beat so the output keeps the last result
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ADD_LEN; i++) begin
                add_valid[i] <= 1'b0;
                add_sum[i]   <= '0;
            end
        end else if (!stall) begin
            add_valid[0] <= mul_valid[MUL_LEN-1];
            if (mul_valid[MUL_LEN-1]) begin
                add_sum[0] <= prod_ext + mul_addend[MUL_LEN-1];
            end
            for (int i = 1; i < ADD_LEN; i++) begin
                add_valid[i] <= add_valid[i-1];
                if (add_valid[i-1]) begin
                    add_sum[i] <= add_sum[i-1];
                end
            end
        end
    end

    // Next occupancy: an op entering and one leaving in the same cycle cancel out
    always_comb begin
        count_next = count;
        if (accept && !out_valid) begin
            count_next = count + CNT_W'(1);
        end else if (!accept && out_valid) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Occupancy counter and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (!stall) begin
            count <= count_next;
            busy  <= (count_next != '0);
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// tb/tb_systolic_mac_pe.sv - self-checking bench for systolic_mac_pe
module tb_systolic_mac_pe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] weight_in = '0;
    logic        weight_load = 1'b0;
    logic        weight_swap = 1'b0;
    logic [15:0] weight_out;
    logic        in_valid = 1'b0;
    logic [15:0] in_value = '0;
    logic [31:0] in_accumulate = '0;
    logic        acc_clear = 1'b0;
    logic        out_pass_valid;
    logic [15:0] out_pass;
    logic        out_valid;
    logic [31:0] out_accumulate;
    logic        busy;

    systolic_mac_pe #(.DATA_W(16), .ACC_W(32), .MUL_LEN(2), .ADD_LEN(3)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
        .weight_out(weight_out),
        .in_valid(in_valid), .in_value(in_value), .in_accumulate(in_accumulate),
        .acc_clear(acc_clear),
        .out_pass_valid(out_pass_valid), .out_pass(out_pass),
        .out_valid(out_valid), .out_accumulate(out_accumulate), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [15:0] weight;
        logic [31:0] acc;
        logic        clr;
        logic [31:0] expect_acc;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [15:0] m_shadow = '0;
    logic [15:0] m_active = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_sum(input logic [15:0] v, input logic [15:0] w,
                                               input logic [31:0] acc, input logic clr);
        int p;
        p = $signed(v) * $signed(w);
        return 32'(p) + (clr ? 32'd0 : acc);
    endfunction

    // One clock of stimulus; updates the weight model and scoreboard for what the PE should accept
    task automatic drive(input bit r, input bit st, input bit iv, input logic [15:0] v,
                         input logic [31:0] acc, input bit clr, input bit ld,
                         input logic [15:0] w, input bit sw, input logic [31:0] exp_r);
        rst = r; stall = st; in_valid = iv; in_value = v; in_accumulate = acc;
        acc_clear = clr; weight_load = ld; weight_in = w; weight_swap = sw;
        if (r) begin
            sb_q.delete();
            m_shadow = '0;
            m_active = '0;
        end else if (!st) begin
            if (iv) sb_q.push_back(exp_r);
            if (sw) m_active = m_shadow;
            if (ld) m_shadow = w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 0, 32'h0);
    endtask

    task automatic load(input logic [15:0] w);
        drive(0, 0, 0, 16'h0, 32'h0, 0, 1, w, 0, 32'h0);
    endtask

    task automatic swap();
        drive(0, 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 1, 32'h0);
    endtask

    task automatic op_e(input logic [15:0] v, input logic [31:0] acc, input bit clr,
                        input logic [31:0] e);
        drive(0, 0, 1, v, acc, clr, 0, 16'h0, 0, e);
    endtask

    task automatic op_m(input logic [15:0] v, input logic [31:0] acc, input bit clr);
        op_e(v, acc, clr, model_sum(v, m_active, acc, clr));
    endtask

    // Result monitor: each unstalled out_valid retires the oldest expected result
    always @(negedge clk) begin
        if (rst === 1'b0 && stall === 1'b0 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: out_valid with nothing pending, out_accumulate=%h",
                         out_accumulate);
            end else begin
                check("sb_result", out_accumulate, sb_q.pop_front());
            end
        end
    end

    initial begin
        vec_t vecs[10];
        int   va, bc, run, max_run, peak, first, ov_cnt;

        vecs[0] = '{16'd7,    16'd3,    32'd100,        1'b0, 32'd121};
        vecs[1] = '{16'h8000, 16'h8000, 32'h7FFF_FFFF,  1'b0, 32'hBFFF_FFFF};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 32'h0,          1'b0, 32'h3FFF_0001};
        vecs[3] = '{16'h7FFF, 16'h8000, 32'h0,          1'b0, 32'hC000_8000};
        vecs[4] = '{16'd5,    16'hFFFD, 32'h1234_5678,  1'b1, 32'hFFFF_FFF1};
        vecs[5] = '{16'hFFFF, 16'd1,    32'h0,          1'b0, 32'hFFFF_FFFF};
        vecs[6] = '{16'd0,    16'd1234, 32'hDEAD_BEEF,  1'b0, 32'hDEAD_BEEF};
        vecs[7] = '{16'd100,  16'hFF9C, 32'd10000,      1'b0, 32'h0};
        vecs[8] = '{16'd1,    16'd1,    32'hFFFF_FFFF,  1'b0, 32'h0};
        vecs[9] = '{16'h8000, 16'h7FFF, 32'h8000_0000,  1'b0, 32'h4000_8000};

        drive(1, 0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 0, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_acc", out_accumulate, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_weight_out", 32'(weight_out), 32'd0);
        check("rst_pass_valid", 32'(out_pass_valid), 32'd0);
        check("rst_pass", 32'(out_pass), 32'd0);

        // Single op: latency, pass-through and busy window
        load(16'd3);
        check("t1_weight_out", 32'(weight_out), 32'd3);
        swap();
        op_e(16'd7, 32'd100, 0, 32'd121);
        check("t1_pass", 32'(out_pass), 32'd7);
        check("t1_pass_valid", 32'(out_pass_valid), 32'd1);
        va = -1;
        bc = 0;
        for (int k = 1; k <= 8; k++) begin
            if (out_valid && va < 0) va = k;
            if (busy) bc++;
            idle();
        end
        check("t1_latency", 32'(va), 32'd5);
        check("t1_busy_cycles", 32'(bc), 32'd5);
        check("t1_hold_acc", out_accumulate, 32'd121);
        check("t1_pass_valid_drop", 32'(out_pass_valid), 32'd0);

        // Back-to-back stream with acc_clear
        load(16'hFFFE);
        swap();
        run = 0;
        max_run = 0;
        peak = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) op_e(16'(k + 1), 32'h5555_5555, 1, 32'(-2 * (k + 1)));
            else idle();
            if (out_valid) run++;
            else run = 0;
            if (run > max_run) max_run = run;
            if (int'(dut.count) > peak) peak = int'(dut.count);
        end
        check("t2_consecutive_valid", 32'(max_run), 32'd8);
        check("t2_count_peak", 32'(peak), 32'd5);
        check("t2_idle_busy", 32'(busy), 32'd0);

        // Swap in the same cycle as an op, then load and swap together
        load(16'd2);
        swap();
        load(16'd5);
        drive(0, 0, 1, 16'd10, 32'h0, 0, 0, 16'h0, 1, 32'd20);
        op_e(16'd10, 32'h0, 0, 32'd50);
        drive(0, 0, 0, 16'h0, 32'h0, 0, 1, 16'd9, 1, 32'h0);
        check("t3_weight_out", 32'(weight_out), 32'd9);
        op_e(16'd3, 32'hFFFF_0000, 1, 32'd15);
        for (int k = 0; k < 6; k++) idle();

        // Table vectors, each loads and activates its own weight
        for (int i = 0; i < 10; i++) begin
            load(vecs[i].weight);
            swap();
            op_e(vecs[i].value, vecs[i].acc, vecs[i].clr, vecs[i].expect_acc);
        end
        for (int k = 0; k < 6; k++) idle();

        // Stall 3 cycles starting 2 cycles after accept; inputs during stall are dropped
        load(16'd5);
        swap();
        load(16'd9);
        op_e(16'd4, 32'd1, 0, 32'd21);
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            if (out_valid && first < 0) first = k;
            if (k >= 2 && k <= 4) drive(0, 1, 1, 16'd99, 32'd7, 0, 1, 16'h1111, 1, 32'h0);
            else idle();
        end
        check("t5_stalled_latency", 32'(first), 32'd8);
        check("t5_weight_held", 32'(weight_out), 32'd9);
        check("t5_pass_held", 32'(out_pass), 32'd4);
        op_e(16'd2, 32'd0, 0, 32'd10);
        for (int k = 0; k < 6; k++) idle();

        // Reset with three ops in flight (stall asserted too: reset wins)
        load(16'd6);
        swap();
        op_m(16'd1, 32'd0, 0);
        op_m(16'd2, 32'd0, 0);
        op_m(16'd3, 32'd0, 0);
        drive(1, 1, 1, 16'd5, 32'd0, 0, 1, 16'd7, 0, 32'h0);
        ov_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) ov_cnt++;
            idle();
        end
        check("t6_no_valid", 32'(ov_cnt), 32'd0);
        check("t6_out_acc", out_accumulate, 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_weight_out", 32'(weight_out), 32'd0);
        check("t6_pass", 32'(out_pass), 32'd0);
        check("t6_count", 32'(dut.count), 32'd0);

        idle();
        idle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
